serial_subtractor: RTL and testbench

//   Bit-serial two's-complement subtractor: computes diff = a - b - bin, LSB first, one bit per clock.
//   It reuses a single full-subtractor cell plus a borrow flip-flop.
//   It is the inverse-direction companion to the team's combinational full-adder cell.

---
 rtl/serial_sub_pkg.sv | 28 ++
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 104 ++++++++++
 tb/tb_serial_subtractor.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and a width-generic reference subtraction for the bit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sub_state_t;

   localparam int MAX_WIDTH = 32;

   // Returns {borrow, diff}; a and b must already fit in 'width' bits.
   function automatic logic [32:0] ref_sub(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic        bin,
                                           input int unsigned width);
      logic [32:0] full_s;
      logic [31:0] mask_s;
      full_s = {1'b0, a} - {1'b0, b} - {32'd0, bin};
      if (width >= 32'd32) begin
         mask_s = 32'hFFFF_FFFF;
      end else begin
         mask_s = (32'd1 << width) - 32'd1;
      end
      return {full_s[32], full_s[31:0] & mask_s};
   endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational full-subtractor cell: d = x - y - bin with borrow-out.
module full_subtractor (
   output logic d,
   output logic bout,
   input  logic x,
   input  logic y,
   input  logic bin
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first, one bit per clock.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   sub_state_t       state_r;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] res_sh_r;
   logic [CNT_W-1:0] cnt_r;
   logic             borrow_q_r;
   logic             a_msb_r;
   logic             b_msb_r;
   logic             d_s;
   logic             bout_s;
   logic [WIDTH-1:0] res_next_s;

   full_subtractor u_cell (
      .d    (d_s),
      .bout (bout_s),
      .x    (a_sh_r[0]),
      .y    (b_sh_r[0]),
      .bin  (borrow_q_r)
   );

   assign res_next_s = {d_s, res_sh_r[WIDTH-1:1]};
   assign ready      = (state_r == IDLE);
   assign busy       = (state_r == SHIFT);

   // Sequencer, datapath shift registers and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         a_sh_r     <= '0;
         b_sh_r     <= '0;
         res_sh_r   <= '0;
         cnt_r      <= '0;
         borrow_q_r <= 1'b0;
         a_msb_r    <= 1'b0;
         b_msb_r    <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow     <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh_r     <= a;
                  b_sh_r     <= b;
                  borrow_q_r <= bin;
                  a_msb_r    <= a[WIDTH-1];
                  b_msb_r    <= b[WIDTH-1];
                  cnt_r      <= '0;
                  state_r    <= SHIFT;
               end
            end
            SHIFT: begin
               a_sh_r     <= a_sh_r >> 1;
               b_sh_r     <= b_sh_r >> 1;
               res_sh_r   <= res_next_s;
               borrow_q_r <= bout_s;
               cnt_r      <= cnt_r + CNT_W'(1);
               // The last cell output is the result MSB, so overflow is judged on d_s.
               if (cnt_r == LAST_CNT) begin
                  state_r <= DONE;
                  done    <= 1'b1;
                  diff    <= res_next_s;
                  borrow  <= bout_s;
                  ovf     <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
               end
            end
            DONE: begin
               done    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               done    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench: vector table on an 8-bit instance, corner sequences, exhaustive 4-bit sweep.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8, bin8, ready8, busy8, done8, borrow8, ovf8;
   logic [7:0] a8, b8, diff8;
   logic       start4, bin4, ready4, busy4, done4, borrow4, ovf4;
   logic [3:0] a4, b4, diff4;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] diff;
      logic       borrow;
      logic       ovf;
   } vec_t;

   vec_t vecs [7];

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .ready(ready8), .busy(busy8), .done(done8), .diff(diff8),
      .borrow(borrow8), .ovf(ovf8)
   );

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
      .ready(ready4), .busy(busy4), .done(done4), .diff(diff4),
      .borrow(borrow4), .ovf(ovf4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic wait_done8(output int n);
      n = 0;
      while (done8 !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_done4(output int n);
      n = 0;
      while (done4 !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int         n;
      bit         seen;
      logic [4:0] e5;
      logic [3:0] ed;
      logic       eo;

      vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h2D, 1'b0, 1'b0};
      vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
      vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
      vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
      vecs[4] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[5] = '{8'h05, 8'h03, 1'b1, 8'h01, 1'b0, 1'b0};
      vecs[6] = '{8'hFF, 8'h80, 1'b0, 8'h7F, 1'b0, 1'b0};

      rst = 1'b1;
      start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
      start4 = 1'b0; a4 = 4'h0;  b4 = 4'h0;  bin4 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready",  {31'd0, ready8},  32'd1);
      chk("rst_busy",   {31'd0, busy8},   32'd0);
      chk("rst_done",   {31'd0, done8},   32'd0);
      chk("rst_diff",   {24'd0, diff8},   32'd0);
      chk("rst_borrow", {31'd0, borrow8}, 32'd0);
      chk("rst_ovf",    {31'd0, ovf8},    32'd0);
      rst = 1'b0;

      // Table-driven operations; operands are scrambled right after acceptance.
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         a8 = vecs[i].a; b8 = vecs[i].b; bin8 = vecs[i].bin; start8 = 1'b1;
         chk($sformatf("v%0d_ready", i), {31'd0, ready8}, 32'd1);
         @(negedge clk);
         start8 = 1'b0; a8 = ~a8; b8 = ~b8; bin8 = ~bin8;
         chk($sformatf("v%0d_busy", i), {31'd0, busy8}, 32'd1);
         wait_done8(n);
         chk($sformatf("v%0d_latency", i), n, 32'd8);
         chk($sformatf("v%0d_diff", i),   {24'd0, diff8},   {24'd0, vecs[i].diff});
         chk($sformatf("v%0d_borrow", i), {31'd0, borrow8}, {31'd0, vecs[i].borrow});
         chk($sformatf("v%0d_ovf", i),    {31'd0, ovf8},    {31'd0, vecs[i].ovf});
         @(negedge clk);
         chk($sformatf("v%0d_done_1cyc", i), {31'd0, done8},  32'd0);
         chk($sformatf("v%0d_ready_aft", i), {31'd0, ready8}, 32'd1);
      end

      // Start pulses during SHIFT and on the DONE->IDLE edge are ignored.
      @(negedge clk);
      a8 = 8'h55; b8 = 8'h22; bin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      chk("ign_ready_shift", {31'd0, ready8}, 32'd0);
      chk("ign_done_early",  {31'd0, done8},  32'd0);
      @(negedge clk);
      chk("ign_done_at8",  {31'd0, done8},  32'd1);
      chk("ign_ready_at8", {31'd0, ready8}, 32'd0);
      chk("ign_diff",      {24'd0, diff8},  32'h33);
      start8 = 1'b1;
      @(negedge clk);
      chk("ign_ready_at9", {31'd0, ready8}, 32'd1);
      chk("ign_busy_at9",  {31'd0, busy8},  32'd0);
      start8 = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (busy8 === 1'b1 || done8 === 1'b1) seen = 1'b1;
      end
      chk("ign_no_restart", {31'd0, seen},  32'd0);
      chk("ign_diff_held",  {24'd0, diff8}, 32'h33);

      // Reset in the middle of SHIFT aborts without a done pulse.
      @(negedge clk);
      a8 = 8'hAA; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_busy_pre", {31'd0, busy8}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_ready",  {31'd0, ready8},  32'd1);
      chk("abort_busy",   {31'd0, busy8},   32'd0);
      chk("abort_done",   {31'd0, done8},   32'd0);
      chk("abort_diff",   {24'd0, diff8},   32'd0);
      chk("abort_borrow", {31'd0, borrow8}, 32'd0);
      chk("abort_ovf",    {31'd0, ovf8},    32'd0);
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done8 === 1'b1) seen = 1'b1;
      end
      chk("abort_no_done", {31'd0, seen}, 32'd0);

      // Exhaustive 4-bit sweep against plain arithmetic.
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               @(negedge clk);
               a4 = 4'(ia); b4 = 4'(ib); bin4 = 1'(ic); start4 = 1'b1;
               @(negedge clk);
               start4 = 1'b0;
               wait_done4(n);
               e5 = {1'b0, a4} - {1'b0, b4} - {4'd0, bin4};
               ed = e5[3:0];
               eo = (a4[3] != b4[3]) && (ed[3] != a4[3]);
               chk($sformatf("w4_%0h_%0h_%0d_res", ia, ib, ic),
                   {26'd0, n[2:0] == 3'd4, ovf4, borrow4, diff4},
                   {26'd0, 1'b1, eo, e5[4], ed});
               @(negedge clk);
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
